// File: rtl/eth_backoff_ctrl.sv
// Truncated binary exponential backoff scheduler for a half-duplex Ethernet MAC (CSMA/CD).
// Optional statistics counters are compiled in with `define ETH_BACKOFF_STATS_EN.
module eth_backoff_ctrl #(
    parameter int unsigned SLOT_CYCLES   = 64,
    parameter int unsigned MAX_ATTEMPTS  = 16,
    parameter int unsigned BACKOFF_LIMIT = 10,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        col_req,
    input  logic        tx_ok,
    input  logic        cancel,
    output logic        busy,
    output logic        retry,
    output logic        abort,
    output logic [4:0]  attempts,
    output logic [9:0]  slots_drawn
`ifdef ETH_BACKOFF_STATS_EN
   ,output logic [15:0] col_total,
    output logic [7:0]  abort_total
`endif
);

    localparam int unsigned       CYC_W    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(SLOT_CYCLES - 1);
    localparam logic [4:0]        MAX_A    = 5'(MAX_ATTEMPTS);
    localparam logic [4:0]        LIMIT_A  = 5'(BACKOFF_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_WAIT,
        S_RETRY,
        S_ABORT
    } state_t;

    state_t           state;
    logic [15:0]      lfsr;
    logic [9:0]       slot_rem;
    logic [CYC_W-1:0] cyc;
    logic [3:0]       k;
    logic [9:0]       draw;
    logic [4:0]       att_next;

    // Exponent is capped, then the low LFSR bits are masked to the 2^k-1 window.
    assign k        = (attempts >= LIMIT_A) ? LIMIT_A[3:0] : attempts[3:0];
    assign draw     = lfsr[9:0] & ~(10'h3FF << k);
    assign att_next = attempts + 5'd1;

    always_ff @(posedge clk) begin
        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        // NOTE: pulse outputs default low every cycle, so they can never stretch past one cycle.
        retry <= 1'b0;
        abort <= 1'b0;
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            attempts    <= '0;
            slots_drawn <= '0;
            slot_rem    <= '0;
            cyc         <= '0;
            lfsr        <= LFSR_SEED;
`ifdef ETH_BACKOFF_STATS_EN
            col_total   <= '0;
            abort_total <= '0;
`endif
        end else if (cancel) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            attempts <= '0;
            slot_rem <= '0;
            cyc      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (col_req) begin
                        attempts <= att_next;
                        busy     <= 1'b1;
`ifdef ETH_BACKOFF_STATS_EN
                        if (col_total != '1) col_total <= col_total + 16'd1;
`endif
                        if (att_next == MAX_A) begin
                            state <= S_ABORT;
                            abort <= 1'b1;
`ifdef ETH_BACKOFF_STATS_EN
                            if (abort_total != '1) abort_total <= abort_total + 8'd1;
`endif
                        end else begin
                            state <= S_DRAW;
                        end
                    end else if (tx_ok) begin
                        attempts <= '0;
                    end
                end
                S_DRAW: begin
                    slots_drawn <= draw;
                    slot_rem    <= draw;
                    cyc         <= '0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (slot_rem == '0) begin
                        state <= S_RETRY;
                        retry <= 1'b1;
                    end else if (cyc == CYC_LAST) begin
                        cyc      <= '0;
                        slot_rem <= slot_rem - 10'd1;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                S_RETRY: begin
                    // attempts is kept so a further collision widens the window.
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                S_ABORT: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    attempts <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_backoff_ctrl.sv
// Self-checking bench for eth_backoff_ctrl: timeline-based reference model plus directed and random stimulus.
// Build with `define ETH_BACKOFF_STATS_EN to also cover the statistics counters.
module tb_eth_backoff_ctrl;

    localparam int          SLOT  = 4;
    localparam int          MAXA  = 16;
    localparam int          LIMIT = 10;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst, col_req, tx_ok, cancel;
    logic       busy, retry, abort;
    logic [4:0] attempts;
    logic [9:0] slots_drawn;
`ifdef ETH_BACKOFF_STATS_EN
    logic [15:0] col_total;
    logic [7:0]  abort_total;
`endif

    eth_backoff_ctrl #(
        .SLOT_CYCLES  (SLOT),
        .MAX_ATTEMPTS (MAXA),
        .BACKOFF_LIMIT(LIMIT),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .col_req    (col_req),
        .tx_ok      (tx_ok),
        .cancel     (cancel),
        .busy       (busy),
        .retry      (retry),
        .abort      (abort),
        .attempts   (attempts),
        .slots_drawn(slots_drawn)
`ifdef ETH_BACKOFF_STATS_EN
       ,.col_total  (col_total),
        .abort_total(abort_total)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted event is turned into absolute cycle numbers at which
    // the outputs must change. Cycle e is the clock period that follows rising edge e.
    longint      now = 0;
    bit          started = 1'b0;
    logic [15:0] m_lfsr;
    int          m_att, m_slots, m_slots_next, m_last_r;
    longint      m_free_at, m_retry_at, m_abort_at, m_slots_at, m_attclr_at;
    int          m_col_total, m_abort_total;

    always @(posedge clk) begin
        longint e;
        bit     idle_prev;
        int     kk;
        e = now + 1;
        now = e;
        started = 1'b1;
        if (rst) begin
            m_lfsr        = SEED;
            m_att         = 0;
            m_slots       = 0;
            m_free_at     = e;
            m_retry_at    = -1;
            m_abort_at    = -1;
            m_slots_at    = -1;
            m_attclr_at   = -1;
            m_col_total   = 0;
            m_abort_total = 0;
        end else begin
            idle_prev = (e - 1 >= m_free_at);
            m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
            if (cancel) begin
                m_att       = 0;
                m_free_at   = e;
                m_retry_at  = -1;
                m_abort_at  = -1;
                m_slots_at  = -1;
                m_attclr_at = -1;
            end else begin
                if (e == m_slots_at) m_slots = m_slots_next;
                if (e == m_attclr_at) m_att = 0;
                if (idle_prev && col_req) begin
                    m_att = m_att + 1;
                    if (m_col_total < 65535) m_col_total++;
                    if (m_att == MAXA) begin
                        m_abort_at  = e;
                        m_free_at   = e + 1;
                        m_attclr_at = e + 1;
                        if (m_abort_total < 255) m_abort_total++;
                    end else begin
                        kk           = (m_att < LIMIT) ? m_att : LIMIT;
                        m_last_r     = int'(m_lfsr[9:0]) % (1 << kk);
                        m_slots_next = m_last_r;
                        m_slots_at   = e + 1;
                        m_retry_at   = e + 2 + longint'(m_last_r) * SLOT;
                        m_free_at    = m_retry_at + 1;
                    end
                end else if (idle_prev && tx_ok) begin
                    m_att = 0;
                end
            end
        end
    end

    // Single compare process: every cycle, all outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            check("busy",        32'(busy),        32'(now < m_free_at));
            check("retry",       32'(retry),       32'(now == m_retry_at));
            check("abort",       32'(abort),       32'(now == m_abort_at));
            check("attempts",    32'(attempts),    32'(m_att));
            check("slots_drawn", 32'(slots_drawn), 32'(m_slots));
            check("lfsr",        32'(dut.lfsr),    32'(m_lfsr));
`ifdef ETH_BACKOFF_STATS_EN
            check("col_total",   32'(col_total),   32'(m_col_total));
            check("abort_total", 32'(abort_total), 32'(m_abort_total));
`endif
        end
    end

    // Pulse col_req for one cycle and count negedges until retry or abort shows up.
    task automatic collide(output int lat);
        col_req = 1'b1;
        @(negedge clk);
        col_req = 1'b0;
        lat = 1;
        while (!retry && !abort && lat < 4200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 4200) check("retry_timeout", 32'(retry), 32'd1);
    endtask

    task automatic wait_retry();
        int n = 0;
        while (!retry && n < 4200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4200) check("wait_retry_timeout", 32'(retry), 32'd1);
    endtask

    initial begin
        int lat;
        int cap;
        int seen;
        bit done;
        rst = 1'b1; col_req = 1'b0; tx_ok = 1'b0; cancel = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_lfsr",     32'(dut.lfsr), 32'hACE1);
        rst = 1'b0;

        // LFSR steps from the seed, pinned by hand.
        @(negedge clk);
        check("lfsr_step1",   32'(dut.lfsr), 32'h59C3);
        @(negedge clk);
        check("lfsr_step2",   32'(dut.lfsr), 32'hB387);
        check("idle_attempts", 32'(attempts), 32'd0);

        // Collisions 1..15 back to back, then the 16th aborts.
        for (int n = 1; n <= MAXA; n++) begin
            collide(lat);
            if (n < MAXA) begin
                cap = (1 << ((n < LIMIT) ? n : LIMIT)) - 1;
                check("retry_latency", 32'(lat), 32'(3 + 4 * m_last_r));
                check("slots_in_cap",  32'(int'(slots_drawn) <= cap), 32'd1);
                check("attempts_n",    32'(attempts), 32'(n));
                if (n == 1) check("r1_range", 32'(slots_drawn <= 10'd1), 32'd1);
                @(negedge clk);
                check("busy_after_retry", 32'(busy), 32'd0);
            end else begin
                check("abort_latency",  32'(lat),      32'd1);
                check("abort_attempts", 32'(attempts), 32'd16);
                @(negedge clk);
                check("post_abort_attempts", 32'(attempts), 32'd0);
                check("post_abort_busy",     32'(busy),     32'd0);
`ifdef ETH_BACKOFF_STATS_EN
                check("col_total_16",  32'(col_total),   32'd16);
                check("abort_total_1", 32'(abort_total), 32'd1);
`endif
            end
        end

        // Cancel in the middle of a nonzero backoff.
        done = 1'b0;
        for (int tries = 0; tries < 10 && !done; tries++) begin
            col_req = 1'b1;
            @(negedge clk);
            col_req = 1'b0;
            @(negedge clk);
            if (m_last_r >= 1) begin
                cancel = 1'b1;
                @(negedge clk);
                cancel = 1'b0;
                check("cancel_busy",     32'(busy),     32'd0);
                check("cancel_attempts", 32'(attempts), 32'd0);
                seen = 0;
                repeat (8) begin
                    @(negedge clk);
                    if (retry) seen++;
                end
                check("cancel_no_retry", 32'(seen), 32'd0);
                done = 1'b1;
            end else begin
                wait_retry();
                @(negedge clk);
            end
        end
        check("cancel_exercised", 32'(done), 32'd1);

        // col_req and tx_ok together: collision wins.
        col_req = 1'b1; tx_ok = 1'b1;
        @(negedge clk);
        col_req = 1'b0; tx_ok = 1'b0;
        check("col_beats_txok_att",  32'(attempts), 32'd1);
        check("col_beats_txok_busy", 32'(busy),     32'd1);
        wait_retry();
        @(negedge clk);
        tx_ok = 1'b1;
        @(negedge clk);
        tx_ok = 1'b0;
        check("txok_clears", 32'(attempts), 32'd0);

        // Randomized traffic, model checked every cycle.
        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(0, 511) == 0);
            cancel  = ($urandom_range(0, 95) == 0);
            col_req = ($urandom_range(0, 3) == 0);
            tx_ok   = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        rst = 1'b0; cancel = 1'b0; col_req = 1'b0; tx_ok = 1'b0;
        repeat (4) @(negedge clk);

        // Final reset clears everything, including statistics.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("final_rst_busy",     32'(busy),     32'd0);
        check("final_rst_attempts", 32'(attempts), 32'd0);
        check("final_rst_slots",    32'(slots_drawn), 32'd0);
`ifdef ETH_BACKOFF_STATS_EN
        check("final_rst_col_total",   32'(col_total),   32'd0);
        check("final_rst_abort_total", 32'(abort_total), 32'd0);
`endif
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
